// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: widths, reset
// defaults, FSM encoding and a word-alignment helper.
package instr_fetch_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [DATA_W-1:0] NOP_WORD     = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Clear the byte-offset bits so a PC always names a whole word.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decoder and redirect signals.
// master = fetch unit side, slave = memory/decoder/pipeline side.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    logic              instr_valid;
    logic              id_ready;
    logic [DATA_W-1:0] instru;
    logic [DATA_W-1:0] pc_out;

    logic              br_taken;
    logic [15:0]       br_off;
    logic              jump;
    logic [25:0]       jmp_idx;
    logic              jr;
    logic [DATA_W-1:0] jr_target;
    logic              flush;
    logic [DATA_W-1:0] flush_pc;
    logic              addr_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instru, pc_out, addr_err,
        input  imem_ack, imem_rdata, id_ready,
        input  br_taken, br_off, jump, jmp_idx, jr, jr_target, flush, flush_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instru, pc_out, addr_err,
        output imem_ack, imem_rdata, id_ready,
        output br_taken, br_off, jump, jmp_idx, jr, jr_target, flush, flush_pc
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the instruction being consumed:
// jr > jump > taken branch > sequential. Reports a misaligned target
// and returns it with the byte-offset bits cleared.
module instr_fetch_unit_next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [DATA_W-1:0] pc_out,
    input  logic [15:0]       br_off,
    input  logic [25:0]       jmp_idx,
    input  logic [DATA_W-1:0] jr_target,
    input  logic              br_taken,
    input  logic              jump,
    input  logic              jr,
    output logic [DATA_W-1:0] next_pc,
    output logic              misalign
);

    logic        [DATA_W-1:0] seq_pc;
    logic signed [DATA_W-1:0] br_disp;
    logic        [DATA_W-1:0] raw_pc;

    // Branch and jump targets are relative to the instruction after pc_out.
    assign seq_pc  = pc_out + 32'd4;
    assign br_disp = {{14{br_off[15]}}, br_off, 2'b00};

    // Priority select of the redirect target.
    always_comb begin
        raw_pc = seq_pc;
        if (jr) begin
            raw_pc = jr_target;
        end else if (jump) begin
            raw_pc = {seq_pc[DATA_W-1:DATA_W-4], jmp_idx, 2'b00};
        end else if (br_taken) begin
            raw_pc = seq_pc + $unsigned(br_disp);
        end
    end

    assign misalign = |raw_pc[1:0];
    assign next_pc  = word_align(raw_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over
// imem req/ack, buffers it for the decoder and redirects on branch, jump,
// jr or flush. A flush that lands on an outstanding request marks it
// killed so its late ack is dropped before the new fetch starts.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              kill_q, kill_d;
    logic [DATA_W-1:0] kill_addr_q, kill_addr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              load_buf;
    logic [DATA_W-1:0] instru_q, pc_out_q;
    logic [DATA_W-1:0] next_pc;
    logic              next_misalign;

    instr_fetch_unit_next_pc_calc u_next_pc (
        .pc_out    (pc_out_q),
        .br_off    (bus.br_off),
        .jmp_idx   (bus.jmp_idx),
        .jr_target (bus.jr_target),
        .br_taken  (bus.br_taken),
        .jump      (bus.jump),
        .jr        (bus.jr),
        .next_pc   (next_pc),
        .misalign  (next_misalign)
    );

    // Next-state and register updates; flush overrides everything else.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        kill_addr_d = kill_addr_q;
        valid_d     = valid_q;
        err_d       = 1'b0;
        load_buf    = 1'b0;
        if (bus.flush) begin
            pc_d    = word_align(bus.flush_pc);
            err_d   = |bus.flush_pc[1:0];
            valid_d = 1'b0;
            state_d = S_REQ;
            if (state_q == S_REQ) begin
                if (bus.imem_ack) begin
                    kill_d = 1'b0;
                end else if (!kill_q) begin
                    kill_d      = 1'b1;
                    kill_addr_d = pc_q;
                end
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else begin
                            load_buf = 1'b1;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + 32'd4;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (valid_q && bus.id_ready) begin
                        valid_d = 1'b0;
                        pc_d    = next_pc;
                        err_d   = next_misalign;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, kill flag, valid and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Address of the killed request; only meaningful while kill_q is set.
    always_ff @(posedge clk) begin
        kill_addr_q <= kill_addr_d;
    end

    // Decoder-facing buffer captures the word and its address on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instru_q <= NOP_WORD;
            pc_out_q <= '0;
        end else if (load_buf) begin
            instru_q <= bus.imem_rdata;
            pc_out_q <= pc_q;
        end
    end

    assign bus.imem_req    = (state_q == S_REQ);
    assign bus.imem_addr   = kill_q ? kill_addr_q : pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instru      = instru_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios followed by random
// traffic, checked against a transaction-level model and a scoreboard.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    typedef struct packed {
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        fl;
        logic [31:0] fpc;
        logic        br;
        logic [15:0] off;
        logic        jp;
        logic [25:0] idx;
        logic        jrr;
        logic [31:0] jt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    // Reference model state (what the outside world should observe).
    logic        m_req, m_req_prev, m_full, m_discard, m_err;
    logic [31:0] m_addr, m_next, m_buf_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.imem_ack   = s.ack;
        bus.imem_rdata = s.rd;
        bus.id_ready   = s.rdy;
        bus.flush      = s.fl;
        bus.flush_pc   = s.fpc;
        bus.br_taken   = s.br;
        bus.br_off     = s.off;
        bus.jump       = s.jp;
        bus.jmp_idx    = s.idx;
        bus.jr         = s.jrr;
        bus.jr_target  = s.jt;
    endtask

    task automatic model_init();
        m_req      = 1'b1;
        m_req_prev = 1'b0;
        m_full     = 1'b0;
        m_discard  = 1'b0;
        m_err      = 1'b0;
        m_addr     = 32'h0;
        m_next     = 32'h0;
        m_buf_pc   = 32'h0;
        exp_q.delete();
    endtask

    // Advance the model across one clock edge given the inputs applied.
    task automatic model_edge(input stim_t s);
        logic        consume;
        logic [31:0] seq, tgt;
        int          disp;
        consume = m_full && s.rdy;
        m_err   = 1'b0;
        if (s.fl) begin
            if (m_full && !consume) exp_q.delete();
            if (m_req) m_discard = !s.ack;
            m_next = s.fpc & ~32'h3;
            m_err  = (s.fpc[1:0] != 2'b00);
            m_full = 1'b0;
            m_req  = 1'b1;
            if (!m_discard) m_addr = m_next;
        end else if (m_req && s.ack) begin
            if (m_discard) begin
                m_discard = 1'b0;
                m_addr    = m_next;
            end else begin
                exp_q.push_back({m_addr, s.rd});
                m_buf_pc = m_addr;
                m_full   = 1'b1;
                m_req    = 1'b0;
            end
        end else if (consume) begin
            seq = m_buf_pc + 32'd4;
            if (s.jrr) begin
                tgt = s.jt;
            end else if (s.jp) begin
                tgt = (seq & 32'hF000_0000) | ({6'd0, s.idx} << 2);
            end else if (s.br) begin
                disp = $signed(s.off);
                tgt  = seq + 32'(disp * 4);
            end else begin
                tgt = seq;
            end
            m_err  = (tgt[1:0] != 2'b00);
            m_next = tgt & ~32'h3;
            m_addr = m_next;
            m_full = 1'b0;
            m_req  = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", bus.imem_addr, m_addr);
        chk("instr_valid", 32'(bus.instr_valid), 32'(m_full));
        chk("addr_err", 32'(bus.addr_err), 32'(m_err));
        if (m_full && exp_q.size() > 0) begin
            chk("buf_instru", bus.instru, exp_q[0].instr);
            chk("buf_pc_out", bus.pc_out, exp_q[0].pc);
        end
    endtask

    task automatic step(input stim_t s);
        drive(s);
        @(posedge clk);
        #1;
        m_req_prev = m_req;
        model_edge(s);
        check_outputs();
    endtask

    task automatic idle();
        stim_t s;
        s = '0;
        step(s);
    endtask

    task automatic fetch(input logic [31:0] rd);
        stim_t s;
        s = '0;
        step(s);
        s.ack = 1'b1;
        s.rd  = rd;
        step(s);
    endtask

    task automatic consume(input stim_t s);
        s.rdy = 1'b1;
        step(s);
    endtask

    // Redirect with a flush coincident with an ack (no kill), then fetch.
    task automatic goto_pc(input logic [31:0] pc);
        stim_t s;
        s = '0;
        step(s);
        s.fl  = 1'b1;
        s.fpc = pc;
        s.ack = 1'b1;
        step(s);
        fetch($urandom);
    endtask

    task automatic apply_reset(input bit check_now);
        stim_t s;
        s   = '0;
        rst = 1'b1;
        drive(s);
        #1;
        if (check_now) begin
            chk("rst_async_valid", 32'(bus.instr_valid), 32'h0);
            chk("rst_async_addr", bus.imem_addr, 32'h0);
            chk("rst_async_req", 32'(bus.imem_req), 32'h1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instru", bus.instru, 32'h0);
        chk("rst_pc_out", bus.pc_out, 32'h0);
        chk("rst_addr_err", 32'(bus.addr_err), 32'h0);
        rst = 1'b0;
        model_init();
        check_outputs();
    endtask

    // Scoreboard monitor: every consume must present the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.instr_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%h required=none", bus.instru);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instru", bus.instru, e.instr);
                    chk("sb_pc_out", bus.pc_out, e.pc);
                end
            end
        end
    end

    initial begin
        stim_t s;
        logic [31:0] r;
        rst = 1'b1;
        s   = '0;
        drive(s);
        @(posedge clk);
        #1;
        apply_reset(1'b0);

        // Sequential fetch from reset
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("seq_addr", bus.imem_addr, 32'(i * 4));
            s = '0;
            s.ack = 1'b1;
            s.rd  = $urandom;
            step(s);
            s = '0;
            consume(s);
        end

        // Branches backward and forward from 0x40
        goto_pc(32'h40);
        s = '0; s.br = 1'b1; s.off = 16'hFFFE;
        consume(s);
        chk("br_back", bus.imem_addr, 32'h3C);
        goto_pc(32'h40);
        s = '0; s.br = 1'b1; s.off = 16'h0003;
        consume(s);
        chk("br_fwd", bus.imem_addr, 32'h50);

        // Jump, then jr winning over jump
        goto_pc(32'h1000_0008);
        s = '0; s.jp = 1'b1; s.idx = 26'h0000100;
        consume(s);
        chk("jump", bus.imem_addr, 32'h1000_0400);
        goto_pc(32'h1000_0008);
        s = '0; s.jp = 1'b1; s.idx = 26'h0000100; s.jrr = 1'b1; s.jt = 32'h80;
        consume(s);
        chk("jr_over_jump", bus.imem_addr, 32'h80);

        // Flush on an outstanding request; late ack is dropped
        idle();
        s = '0; s.fl = 1'b1; s.fpc = 32'h180;
        step(s);
        chk("kill_old_addr", bus.imem_addr, 32'h80);
        idle();
        idle();
        s = '0; s.ack = 1'b1; s.rd = 32'hDEAD_BEEF;
        step(s);
        chk("late_ack_dropped", 32'(bus.instr_valid), 32'h0);
        chk("restart_addr", bus.imem_addr, 32'h180);
        fetch(32'h1234_5678);
        s = '0;
        consume(s);

        // Decoder stall with a stray ack
        fetch(32'hCAFE_0001);
        for (int k = 0; k < 5; k++) begin
            s = '0;
            s.ack = (k == 2);
            s.rd  = 32'hBAD0_0000;
            step(s);
            chk("stall_req_low", 32'(bus.imem_req), 32'h0);
        end
        s = '0;
        consume(s);

        // Misaligned jr target
        goto_pc(32'h200);
        s = '0; s.jrr = 1'b1; s.jt = 32'h0000_0102;
        consume(s);
        chk("misalign_addr", bus.imem_addr, 32'h100);
        chk("misalign_err", 32'(bus.addr_err), 32'h1);
        idle();
        chk("misalign_err_drop", 32'(bus.addr_err), 32'h0);

        // Reset while holding an instruction, then while a request is killed
        fetch(32'h0BAD_F00D);
        apply_reset(1'b1);
        idle();
        s = '0; s.fl = 1'b1; s.fpc = 32'h300;
        step(s);
        apply_reset(1'b1);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            s = '0;
            if (m_req) s.ack = m_req_prev && ($urandom_range(0, 2) != 0);
            else       s.ack = ($urandom_range(0, 9) == 0);
            s.rd  = $urandom;
            s.rdy = ($urandom_range(0, 9) < 6);
            s.fl  = ($urandom_range(0, 19) == 0);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            s.fpc = r;
            s.br  = ($urandom_range(0, 2) == 0);
            s.off = 16'($urandom);
            s.jp  = ($urandom_range(0, 2) == 0);
            s.idx = 26'($urandom);
            s.jrr = ($urandom_range(0, 3) == 0);
            r = $urandom;
            if ($urandom_range(0, 2) != 0) r[1:0] = 2'b00;
            s.jt  = r;
            step(s);
        end

        s = '0;
        drive(s);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
